tag_multicaster: RTL and testbench



---
 rtl/tag_multicaster.sv | 112 +++++++++++
 tb/tb_tag_multicaster.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_multicaster.sv
// rtl/tag_multicaster.sv - tag-matching multi-channel column caster with per-channel FWFT FIFOs
// Optional MCAST_DROP_CNT_EN: per-channel saturating discarded-beat counters on drop_cnt.

module tag_multicaster #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_COL    = 4,
  parameter int NUM_CH     = 3,
  parameter int FIFO_DEPTH = 4,
  localparam int TAG_W     = (NUM_COL > 2) ? $clog2(NUM_COL) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         caster_en,
  input  logic                         cfg_wen,
  input  logic [TAG_W-1:0]             cfg_id,
  output logic [TAG_W-1:0]             id_q,
  input  logic [NUM_CH-1:0]            bus_valid,
  output logic [NUM_CH-1:0]            bus_ready,
  input  logic [NUM_CH*TAG_W-1:0]      bus_tag,
  input  logic [NUM_CH-1:0]            bus_bcast,
  input  logic [NUM_CH*DATA_WIDTH-1:0] bus_data,
  output logic [NUM_CH-1:0]            pe_valid,
  input  logic [NUM_CH-1:0]            pe_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0] pe_data,
  output logic                         busy,
  output logic [NUM_CH*16-1:0]         drop_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  // A beat in the same cycle as cfg_wen still sees the old ID, since id_q is registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_q <= '0;
    end else if (cfg_wen) begin
      id_q <= cfg_id;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  match, full, empty, push, pop;

    assign match = bus_bcast[c] | (bus_tag[c*TAG_W +: TAG_W] == id_q);
    assign full  = (cnt_q == FULL_CNT);
    assign empty = (cnt_q == '0);

    // Non-matching beats are always consumed so a foreign stream never stalls the bus.
    assign bus_ready[c] = !rst && caster_en && (!match || !full);
    assign push         = bus_valid[c] && bus_ready[c] && match;
    assign pop          = !empty && pe_ready[c];

    assign pe_valid[c]                          = !empty;
    assign pe_data[c*DATA_WIDTH +: DATA_WIDTH]  = mem_q[rd_ptr_q];

    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else if (pop && !push) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
      end
    end

    always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= bus_data[c*DATA_WIDTH +: DATA_WIDTH];
    end

`ifdef MCAST_DROP_CNT_EN
    logic [15:0] drop_q;
    logic        drop;

    assign drop = bus_valid[c] && bus_ready[c] && !match;

    always_ff @(posedge clk) begin
      if (rst || cfg_wen) begin
        drop_q <= '0;
      end else if (drop && (drop_q != 16'hFFFF)) begin
        drop_q <= drop_q + 16'd1;
      end
    end

    assign drop_cnt[c*16 +: 16] = drop_q;
`else
    assign drop_cnt[c*16 +: 16] = 16'd0;
`endif
  end

  assign busy = |pe_valid;

endmodule

// File: tb/tb_tag_multicaster.sv
// tb/tb_tag_multicaster.sv - directed self-checking bench for tag_multicaster
// Drop-count expectations follow MCAST_DROP_CNT_EN.

module tb_tag_multicaster;

  logic        clk = 1'b0;
  logic        rst;
  logic        caster_en;
  logic        cfg_wen;
  logic [1:0]  cfg_id;
  logic [1:0]  id_q;
  logic [2:0]  bus_valid;
  logic [2:0]  bus_ready;
  logic [5:0]  bus_tag;
  logic [2:0]  bus_bcast;
  logic [47:0] bus_data;
  logic [2:0]  pe_valid;
  logic [2:0]  pe_ready;
  logic [47:0] pe_data;
  logic        busy;
  logic [47:0] drop_cnt;

  int errors = 0;
  int checks = 0;

`ifdef MCAST_DROP_CNT_EN
  localparam logic [15:0] EXP_DROP3 = 16'd3;
  localparam logic [15:0] EXP_DROP2 = 16'd2;
`else
  localparam logic [15:0] EXP_DROP3 = 16'd0;
  localparam logic [15:0] EXP_DROP2 = 16'd0;
`endif

  tag_multicaster #(
    .DATA_WIDTH(16),
    .NUM_COL   (4),
    .NUM_CH    (3),
    .FIFO_DEPTH(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .caster_en(caster_en),
    .cfg_wen  (cfg_wen),
    .cfg_id   (cfg_id),
    .id_q     (id_q),
    .bus_valid(bus_valid),
    .bus_ready(bus_ready),
    .bus_tag  (bus_tag),
    .bus_bcast(bus_bcast),
    .bus_data (bus_data),
    .pe_valid (pe_valid),
    .pe_ready (pe_ready),
    .pe_data  (pe_data),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst       = 1'b1;
    caster_en = 1'b1;
    cfg_wen   = 1'b0;
    cfg_id    = 2'd0;
    bus_valid = 3'b111;
    bus_tag   = 6'd0;
    bus_bcast = 3'b000;
    bus_data  = 48'h0;
    pe_ready  = 3'b000;

    // Reset
    #1;
    chk("ready_in_rst", bus_ready, 3'b000);
    tick();
    chk("rst_pe_valid", pe_valid, 3'b000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_id", id_q, 2'd0);
    chk("rst_drop", drop_cnt, 48'h0);
    chk("ready_in_rst2", bus_ready, 3'b000);
    rst       = 1'b0;
    bus_valid = 3'b000;
    tick();

    // Single beat on ch0
    cfg_wen = 1'b1;
    cfg_id  = 2'd2;
    tick();
    cfg_wen = 1'b0;
    chk("cfg_id2", id_q, 2'd2);
    pe_ready      = 3'b111;
    bus_valid[0]  = 1'b1;
    bus_tag[1:0]  = 2'd2;
    bus_data[15:0] = 16'h1234;
    #1;
    chk("t1_ready", bus_ready[0], 1'b1);
    tick();
    bus_valid[0] = 1'b0;
    chk("t1_valid", pe_valid[0], 1'b1);
    chk("t1_data", pe_data[15:0], 16'h1234);
    chk("t1_busy", busy, 1'b1);
    tick();
    chk("t1_valid_gone", pe_valid[0], 1'b0);
    chk("t1_busy_gone", busy, 1'b0);

    // ch1 fills under backpressure while ch0 streams
    pe_ready     = 3'b101;
    bus_valid    = 3'b011;
    bus_tag[3:2] = 2'd2;
    for (int i = 1; i <= 5; i++) begin
      bus_data[15:0]  = 16'hA000 + 16'(i);
      bus_data[31:16] = 16'(i);
      #1;
      chk("t2_ready_ch1", bus_ready[1], (i <= 4) ? 1'b1 : 1'b0);
      chk("t2_ready_ch0", bus_ready[0], 1'b1);
      if (i > 1) chk("t2_data_ch0", pe_data[15:0], 16'hA000 + 16'(i - 1));
      tick();
    end
    bus_valid[0] = 1'b0;
    chk("t2_ch2_idle", pe_valid[2], 1'b0);
    chk("t2_ch1_valid", pe_valid[1], 1'b1);
    pe_ready[1] = 1'b1;
    #1;
    chk("t2_head1", pe_data[31:16], 16'd1);
    chk("t2_full_ready", bus_ready[1], 1'b0);
    tick();
    chk("t2_head2", pe_data[31:16], 16'd2);
    chk("t2_freed_ready", bus_ready[1], 1'b1);
    tick();
    bus_valid[1] = 1'b0;
    chk("t2_head3", pe_data[31:16], 16'd3);
    tick();
    chk("t2_head4", pe_data[31:16], 16'd4);
    tick();
    chk("t2_head5", pe_data[31:16], 16'd5);
    tick();
    chk("t2_ch1_empty", pe_valid[1], 1'b0);

    // Tag filtering on ch2
    cfg_wen = 1'b1;
    cfg_id  = 2'd1;
    tick();
    cfg_wen      = 1'b0;
    pe_ready     = 3'b111;
    bus_valid[2] = 1'b1;
    for (int t = 0; t < 4; t++) begin
      bus_tag[5:4]    = 2'(t);
      bus_data[47:32] = 16'hC000 + 16'(t);
      #1;
      chk("t3_ready", bus_ready[2], 1'b1);
      tick();
      chk("t3_valid", pe_valid[2], (t == 1) ? 1'b1 : 1'b0);
      if (t == 1) chk("t3_data", pe_data[47:32], 16'hC001);
    end
    bus_valid[2] = 1'b0;
    chk("t3_drop", drop_cnt[47:32], EXP_DROP3);

    // Beat alongside cfg_wen matches the old ID
    bus_valid[0]   = 1'b1;
    bus_tag[1:0]   = 2'd1;
    bus_data[15:0] = 16'h3B3B;
    cfg_wen        = 1'b1;
    cfg_id         = 2'd3;
    #1;
    chk("t3b_ready", bus_ready[0], 1'b1);
    tick();
    cfg_wen = 1'b0;
    chk("t3b_id", id_q, 2'd3);
    chk("t3b_valid", pe_valid[0], 1'b1);
    chk("t3b_data", pe_data[15:0], 16'h3B3B);

    // Broadcast, then the same beat with caster disabled
    bus_tag[1:0]   = 2'd0;
    bus_bcast[0]   = 1'b1;
    bus_data[15:0] = 16'hBBBB;
    #1;
    chk("t4_bc_ready", bus_ready[0], 1'b1);
    tick();
    bus_valid[0] = 1'b0;
    chk("t4_bc_valid", pe_valid[0], 1'b1);
    chk("t4_bc_data", pe_data[15:0], 16'hBBBB);
    tick();
    chk("t4_empty", pe_valid[0], 1'b0);
    caster_en    = 1'b0;
    bus_valid[0] = 1'b1;
    #1;
    chk("t4_dis_ready", bus_ready, 3'b000);
    tick();
    chk("t4_dis_nopush", pe_valid[0], 1'b0);
    caster_en    = 1'b1;
    bus_valid[0] = 1'b0;
    bus_bcast[0] = 1'b0;

    // Steady push+pop with two in flight across pointer wrap
    pe_ready[1]     = 1'b0;
    bus_valid[1]    = 1'b1;
    bus_tag[3:2]    = 2'd3;
    bus_data[31:16] = 16'hD000;
    tick();
    bus_data[31:16] = 16'hD001;
    tick();
    pe_ready[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus_data[31:16] = 16'hD002 + 16'(k);
      #1;
      chk("t5_head", pe_data[31:16], 16'hD000 + 16'(k));
      chk("t5_ready", bus_ready[1], 1'b1);
      tick();
    end
    bus_valid[1] = 1'b0;
    chk("t5_tail0", pe_data[31:16], 16'hD00A);
    tick();
    chk("t5_tail1", pe_data[31:16], 16'hD00B);
    tick();
    chk("t5_empty", pe_valid[1], 1'b0);

    // Reset mid-operation
    pe_ready     = 3'b000;
    bus_valid    = 3'b111;
    bus_tag      = {2'd0, 2'd3, 2'd3};
    bus_data     = {16'h5555, 16'h4444, 16'h3333};
    tick();
    tick();
    chk("t6_busy_pre", busy, 1'b1);
    chk("t6_drop_pre", drop_cnt[47:32], EXP_DROP2);
    rst = 1'b1;
    #1;
    chk("t6_ready_rst", bus_ready, 3'b000);
    tick();
    chk("t6_pe_valid", pe_valid, 3'b000);
    chk("t6_busy", busy, 1'b0);
    chk("t6_id", id_q, 2'd0);
    chk("t6_drop", drop_cnt, 48'h0);
    rst       = 1'b0;
    bus_valid = 3'b000;
    tick();
    chk("t6_no_partial", pe_valid, 3'b000);

    // Drop counter saturation (or absence)
    bus_valid    = 3'b100;
    bus_tag[5:4] = 2'd1;
`ifdef MCAST_DROP_CNT_EN
    repeat (70000) tick();
    chk("t7_ready", bus_ready[2], 1'b1);
    chk("t7_drop_sat", drop_cnt[47:32], 16'hFFFF);
`else
    repeat (5) tick();
    chk("t7_ready", bus_ready[2], 1'b1);
    chk("t7_drop_none", drop_cnt, 48'h0);
`endif
    chk("t7_no_push", pe_valid[2], 1'b0);
    bus_valid = 3'b000;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
